// File: rtl/ghost_mode_ctrl.sv
// ghost_mode_ctrl
//   Per-ghost behaviour-mode sequencer feeding the movement/steering block.
//   Owns all mode timing: FRIGHTEN after a power pellet, DEAD after being
//   eaten, respawn back to the chase/scatter phase. Also detects ghost/player
//   overlap and reports a caught player or an eaten ghost.
//
//   Optional feature macro: GHOST_SCATTER_EN
//     defined   -> SCATTER/CHASE phase alternation, reset mode SCATTER
//     undefined -> no phase counter, mode never SCATTER, reset mode CHASE
//
//   Pixel coordinate widths come from `WIDTH / `HEIGHT (defaulted below).
//
// Ports
//   clk            system clock
//   rst            synchronous active-high reset
//   tick           one-cycle frame-tick strobe
//   pellet_eaten   one-cycle strobe, power pellet consumed
//   ghost_x/_y     ghost pixel position
//   player_x/_y    player pixel position
//   mode           00 CHASE, 01 FRIGHTEN, 10 DEAD, 11 SCATTER (registered)
//   timer          remaining ticks in FRIGHTEN/DEAD, 0 otherwise
//   frighten_warn  FRIGHTEN with timer at or below WARN_TICKS
//   player_caught  one-cycle pulse, rising overlap in CHASE/SCATTER
//   ghost_eaten    one-cycle pulse, overlap while FRIGHTEN
//   respawn        one-cycle pulse, DEAD period ended
//
// State     | meaning
// ----------+----------------------------------------------------------
// CHASE     | normal pursuit; pellet -> FRIGHTEN, overlap edge -> caught
// FRIGHTEN  | ghost edible; timer counts down on ticks, pellet reloads
// DEAD      | eyes returning home; timer counts down, then respawn
// SCATTER   | same rules as CHASE, only with GHOST_SCATTER_EN

`ifndef WIDTH
`define WIDTH 320
`endif
`ifndef HEIGHT
`define HEIGHT 240
`endif

module ghost_mode_ctrl #(
    parameter int FRIGHTEN_TICKS = 360,
    parameter int WARN_TICKS     = 120,
    parameter int DEAD_TICKS     = 180,
    parameter int HIT_DIST       = 8,
    parameter int SCATTER_TICKS  = 420,
    parameter int CHASE_TICKS    = 1200
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tick,
    input  logic                         pellet_eaten,
    input  logic [$clog2(`WIDTH)-1:0]    ghost_x,
    input  logic [$clog2(`HEIGHT)-1:0]   ghost_y,
    input  logic [$clog2(`WIDTH)-1:0]    player_x,
    input  logic [$clog2(`HEIGHT)-1:0]   player_y,
    output logic [1:0]                   mode,
    output logic [11:0]                  timer,
    output logic                         frighten_warn,
    output logic                         player_caught,
    output logic                         ghost_eaten,
    output logic                         respawn
);

    localparam int XW = $clog2(`WIDTH);
    localparam int YW = $clog2(`HEIGHT);

    localparam logic [11:0] FRIGHTEN_LD = 12'(FRIGHTEN_TICKS);
    localparam logic [11:0] DEAD_LD     = 12'(DEAD_TICKS);
    localparam logic [11:0] WARN_LD     = 12'(WARN_TICKS);
    // One extra bit so a HIT_DIST equal to 2**XW still compares correctly.
    localparam logic [XW:0] HIT_X       = HIT_DIST[XW:0];
    localparam logic [YW:0] HIT_Y       = HIT_DIST[YW:0];

    typedef enum logic [1:0] {
        CHASE    = 2'b00,
        FRIGHTEN = 2'b01,
        DEAD     = 2'b10,
        SCATTER  = 2'b11
    } mode_t;

`ifdef GHOST_SCATTER_EN
    localparam mode_t       RESET_MODE = SCATTER;
    localparam logic [11:0] SCATTER_LD = 12'(SCATTER_TICKS);
    localparam logic [11:0] CHASE_LD   = 12'(CHASE_TICKS);
`else
    localparam mode_t       RESET_MODE = CHASE;
    logic unused_phase_cfg;
    assign unused_phase_cfg = ^{12'(SCATTER_TICKS), 12'(CHASE_TICKS)};
`endif

    mode_t       mode_q, mode_nxt, home_mode;
    logic [11:0] timer_q, timer_nxt;
    logic        warn_q, warn_nxt;
    logic        caught_q, caught_nxt;
    logic        eaten_q, eaten_nxt;
    logic        respawn_q, respawn_nxt;
    logic        overlap, overlap_q;

`ifdef GHOST_SCATTER_EN
    logic [11:0] phase_cnt_q, phase_cnt_nxt;
    logic        phase_scatter_q, phase_scatter_nxt;
`endif

    // Magnitudes are formed by subtracting the smaller from the larger so a
    // far-apart pair can never wrap into a small difference.
    logic [XW-1:0] dx;
    logic [YW-1:0] dy;

    always_comb begin
        dx      = (ghost_x >= player_x) ? (ghost_x - player_x) : (player_x - ghost_x);
        dy      = (ghost_y >= player_y) ? (ghost_y - player_y) : (player_y - ghost_y);
        overlap = ({1'b0, dx} < HIT_X) && ({1'b0, dy} < HIT_Y);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q          <= RESET_MODE;
            timer_q         <= 12'd0;
            warn_q          <= 1'b0;
            caught_q        <= 1'b0;
            eaten_q         <= 1'b0;
            respawn_q       <= 1'b0;
            overlap_q       <= 1'b0;
`ifdef GHOST_SCATTER_EN
            phase_cnt_q     <= SCATTER_LD;
            phase_scatter_q <= 1'b1;
`endif
        end else begin
            mode_q          <= mode_nxt;
            timer_q         <= timer_nxt;
            warn_q          <= warn_nxt;
            caught_q        <= caught_nxt;
            eaten_q         <= eaten_nxt;
            respawn_q       <= respawn_nxt;
            overlap_q       <= overlap;
`ifdef GHOST_SCATTER_EN
            phase_cnt_q     <= phase_cnt_nxt;
            phase_scatter_q <= phase_scatter_nxt;
`endif
        end
    end

    always_comb begin
        mode_nxt    = mode_q;
        timer_nxt   = timer_q;
        caught_nxt  = 1'b0;
        eaten_nxt   = 1'b0;
        respawn_nxt = 1'b0;

`ifdef GHOST_SCATTER_EN
        // Phase counter only runs in CHASE/SCATTER; it is frozen during
        // FRIGHTEN/DEAD so the ghost resumes the phase it left.
        phase_cnt_nxt     = phase_cnt_q;
        phase_scatter_nxt = phase_scatter_q;
        if (tick && (mode_q == CHASE || mode_q == SCATTER)) begin
            if (phase_cnt_q <= 12'd1) begin
                phase_scatter_nxt = !phase_scatter_q;
                phase_cnt_nxt     = phase_scatter_q ? CHASE_LD : SCATTER_LD;
            end else begin
                phase_cnt_nxt = phase_cnt_q - 12'd1;
            end
        end
        home_mode = phase_scatter_nxt ? SCATTER : CHASE;
`else
        home_mode = CHASE;
`endif

        case (mode_q)
            CHASE, SCATTER: begin
                timer_nxt = 12'd0;
                if (pellet_eaten) begin
                    mode_nxt  = FRIGHTEN;
                    timer_nxt = FRIGHTEN_LD;
                end else begin
                    mode_nxt   = home_mode;
                    caught_nxt = overlap && !overlap_q;
                end
            end
            FRIGHTEN: begin
                if (overlap) begin
                    eaten_nxt = 1'b1;
                    mode_nxt  = DEAD;
                    timer_nxt = DEAD_LD;
                end else if (pellet_eaten) begin
                    timer_nxt = FRIGHTEN_LD;
                end else if (tick) begin
                    if (timer_q <= 12'd1) begin
                        mode_nxt  = home_mode;
                        timer_nxt = 12'd0;
                    end else begin
                        timer_nxt = timer_q - 12'd1;
                    end
                end
            end
            DEAD: begin
                if (tick) begin
                    if (timer_q <= 12'd1) begin
                        mode_nxt    = home_mode;
                        timer_nxt   = 12'd0;
                        respawn_nxt = 1'b1;
                    end else begin
                        timer_nxt = timer_q - 12'd1;
                    end
                end
            end
            default: begin
                mode_nxt  = home_mode;
                timer_nxt = 12'd0;
            end
        endcase

        warn_nxt = (mode_nxt == FRIGHTEN) && (timer_nxt <= WARN_LD);
    end

    assign mode          = mode_q;
    assign timer         = timer_q;
    assign frighten_warn = warn_q;
    assign player_caught = caught_q;
    assign ghost_eaten   = eaten_q;
    assign respawn       = respawn_q;

endmodule

// File: tb/tb_ghost_mode_ctrl.sv
`ifndef WIDTH
`define WIDTH 320
`endif
`ifndef HEIGHT
`define HEIGHT 240
`endif

module tb_ghost_mode_ctrl;

    localparam int XW = $clog2(`WIDTH);
    localparam int YW = $clog2(`HEIGHT);

    logic          clk = 1'b0;
    logic          rst;
    logic          tick;
    logic          pellet_eaten;
    logic [XW-1:0] ghost_x, player_x;
    logic [YW-1:0] ghost_y, player_y;
    logic [1:0]    mode;
    logic [11:0]   timer;
    logic          frighten_warn, player_caught, ghost_eaten, respawn;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ghost_mode_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .tick          (tick),
        .pellet_eaten  (pellet_eaten),
        .ghost_x       (ghost_x),
        .ghost_y       (ghost_y),
        .player_x      (player_x),
        .player_y      (player_y),
        .mode          (mode),
        .timer         (timer),
        .frighten_warn (frighten_warn),
        .player_caught (player_caught),
        .ghost_eaten   (ghost_eaten),
        .respawn       (respawn)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic set_pos(input int gx, input int gy, input int px, input int py);
        ghost_x  = XW'(gx);
        ghost_y  = YW'(gy);
        player_x = XW'(px);
        player_y = YW'(py);
    endtask

    task automatic far();
        set_pos(10, 10, 200, 200);
    endtask

    task automatic near();
        set_pos(100, 100, 105, 103);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick = 1'b0;
        pellet_eaten = 1'b0;
        far();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (mode !== 2'b00) begin errors++; $display("FAIL reset_mode: got %0d expected 0", mode); end
        checks++; if (timer !== 12'd0) begin errors++; $display("FAIL reset_timer: got %0d expected 0", timer); end
        checks++; if (frighten_warn !== 1'b0) begin errors++; $display("FAIL reset_warn: got %0b expected 0", frighten_warn); end
        checks++; if ({player_caught, ghost_eaten, respawn} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses: got %b expected 000", {player_caught, ghost_eaten, respawn});
        end
    endtask

    task automatic test_idle();
        int bad = 0;
        far();
        repeat (1000) begin
            do_tick();
            if (mode !== 2'b00 || timer !== 12'd0 || frighten_warn !== 1'b0 ||
                player_caught !== 1'b0 || ghost_eaten !== 1'b0 || respawn !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL idle_1000_ticks: bad cycles %0d expected 0", bad); end
    endtask

    task automatic test_frighten();
        logic [1:0]  exp_m;
        logic [11:0] exp_t;
        logic        exp_w;
        pellet_eaten = 1'b1;
        cyc();
        pellet_eaten = 1'b0;
        checks++; if (mode !== 2'b01) begin errors++; $display("FAIL fr_enter_mode: got %0d expected 1", mode); end
        checks++; if (timer !== 12'd360) begin errors++; $display("FAIL fr_enter_timer: got %0d expected 360", timer); end
        checks++; if (frighten_warn !== 1'b0) begin errors++; $display("FAIL fr_enter_warn: got %0b expected 0", frighten_warn); end
        for (int i = 1; i <= 360; i++) begin
            do_tick();
            exp_t = (i < 360) ? 12'(360 - i) : 12'd0;
            exp_m = (i < 360) ? 2'b01 : 2'b00;
            exp_w = (i < 360) && (exp_t <= 12'd120);
            checks++; if (mode !== exp_m) begin errors++; $display("FAIL fr_mode tick %0d: got %0d expected %0d", i, mode, exp_m); end
            checks++; if (timer !== exp_t) begin errors++; $display("FAIL fr_timer tick %0d: got %0d expected %0d", i, timer, exp_t); end
            checks++; if (frighten_warn !== exp_w) begin errors++; $display("FAIL fr_warn tick %0d: got %0b expected %0b", i, frighten_warn, exp_w); end
        end
        cyc();
        checks++; if (mode !== 2'b00 || timer !== 12'd0) begin
            errors++; $display("FAIL fr_after: got mode %0d timer %0d expected 0 0", mode, timer);
        end
    endtask

    task automatic test_eaten();
        pellet_eaten = 1'b1;
        cyc();
        pellet_eaten = 1'b0;
        repeat (160) do_tick();
        checks++; if (timer !== 12'd200 || mode !== 2'b01 || frighten_warn !== 1'b0) begin
            errors++; $display("FAIL eat_pre: got mode %0d timer %0d warn %0b expected 1 200 0", mode, timer, frighten_warn);
        end
        near();
        cyc();
        checks++; if (ghost_eaten !== 1'b1) begin errors++; $display("FAIL eat_pulse: got %0b expected 1", ghost_eaten); end
        checks++; if (mode !== 2'b10) begin errors++; $display("FAIL eat_mode: got %0d expected 2", mode); end
        checks++; if (timer !== 12'd180) begin errors++; $display("FAIL eat_timer: got %0d expected 180", timer); end
        checks++; if (player_caught !== 1'b0 || frighten_warn !== 1'b0) begin
            errors++; $display("FAIL eat_side: got caught %0b warn %0b expected 0 0", player_caught, frighten_warn);
        end
        pellet_eaten = 1'b1;
        cyc();
        pellet_eaten = 1'b0;
        checks++; if (ghost_eaten !== 1'b0 || mode !== 2'b10 || timer !== 12'd180 || player_caught !== 1'b0) begin
            errors++; $display("FAIL dead_ignore: got eaten %0b mode %0d timer %0d caught %0b expected 0 2 180 0",
                               ghost_eaten, mode, timer, player_caught);
        end
        far();
        for (int i = 1; i <= 180; i++) begin
            do_tick();
            if (i < 180) begin
                checks++; if (mode !== 2'b10 || timer !== 12'(180 - i) || respawn !== 1'b0) begin
                    errors++; $display("FAIL dead_count tick %0d: got mode %0d timer %0d respawn %0b expected 2 %0d 0",
                                       i, mode, timer, respawn, 180 - i);
                end
            end else begin
                checks++; if (mode !== 2'b00 || timer !== 12'd0 || respawn !== 1'b1) begin
                    errors++; $display("FAIL dead_respawn: got mode %0d timer %0d respawn %0b expected 0 0 1", mode, timer, respawn);
                end
            end
        end
        cyc();
        checks++; if (respawn !== 1'b0) begin errors++; $display("FAIL respawn_width: got %0b expected 0", respawn); end
    endtask

    task automatic test_caught();
        int pulses = 0;
        far();
        cyc();
        near();
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (i == 0) begin
                checks++; if (player_caught !== 1'b1) begin errors++; $display("FAIL caught_first: got %0b expected 1", player_caught); end
            end
            if (player_caught === 1'b1) pulses++;
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL caught_hold: got %0d pulses expected 1", pulses); end
        checks++; if (mode !== 2'b00) begin errors++; $display("FAIL caught_mode: got %0d expected 0", mode); end
        far();
        cyc();
        cyc();
        near();
        cyc();
        checks++; if (player_caught !== 1'b1) begin errors++; $display("FAIL caught_second: got %0b expected 1", player_caught); end
        cyc();
        checks++; if (player_caught !== 1'b0) begin errors++; $display("FAIL caught_width: got %0b expected 0", player_caught); end

        far(); cyc();
        set_pos(100, 100, 108, 100); cyc();
        checks++; if (player_caught !== 1'b0) begin errors++; $display("FAIL hit_dx8: got %0b expected 0", player_caught); end
        set_pos(100, 100, 107, 100); cyc();
        checks++; if (player_caught !== 1'b1) begin errors++; $display("FAIL hit_dx7: got %0b expected 1", player_caught); end
        far(); cyc();
        set_pos(100, 100, 100, 92); cyc();
        checks++; if (player_caught !== 1'b0) begin errors++; $display("FAIL hit_dy8: got %0b expected 0", player_caught); end
        set_pos(100, 100, 100, 93); cyc();
        checks++; if (player_caught !== 1'b1) begin errors++; $display("FAIL hit_dy7: got %0b expected 1", player_caught); end
        far(); cyc();
        set_pos(2, 50, 509, 50); cyc();
        checks++; if (player_caught !== 1'b0) begin errors++; $display("FAIL hit_nowrap: got %0b expected 0", player_caught); end

        far(); cyc();
        near();
        pellet_eaten = 1'b1;
        cyc();
        pellet_eaten = 1'b0;
        checks++; if (player_caught !== 1'b0 || mode !== 2'b01 || timer !== 12'd360) begin
            errors++; $display("FAIL pellet_over_catch: got caught %0b mode %0d timer %0d expected 0 1 360", player_caught, mode, timer);
        end
        cyc();
        checks++; if (ghost_eaten !== 1'b1 || mode !== 2'b10) begin
            errors++; $display("FAIL level_eat: got eaten %0b mode %0d expected 1 2", ghost_eaten, mode);
        end
        do_reset();
        checks++; if (mode !== 2'b00 || timer !== 12'd0 || ghost_eaten !== 1'b0) begin
            errors++; $display("FAIL reset_abort_dead: got mode %0d timer %0d eaten %0b expected 0 0 0", mode, timer, ghost_eaten);
        end
    endtask

    task automatic test_back_to_back();
        pellet_eaten = 1'b1;
        cyc();
        pellet_eaten = 1'b0;
        repeat (359) do_tick();
        checks++; if (timer !== 12'd1 || frighten_warn !== 1'b1) begin
            errors++; $display("FAIL b2b_t1: got timer %0d warn %0b expected 1 1", timer, frighten_warn);
        end
        tick = 1'b1;
        pellet_eaten = 1'b1;
        cyc();
        tick = 1'b0;
        pellet_eaten = 1'b0;
        checks++; if (mode !== 2'b01 || timer !== 12'd360 || frighten_warn !== 1'b0) begin
            errors++; $display("FAIL b2b_reload: got mode %0d timer %0d warn %0b expected 1 360 0", mode, timer, frighten_warn);
        end
        repeat (359) do_tick();
        checks++; if (timer !== 12'd1) begin errors++; $display("FAIL b2b_t1b: got %0d expected 1", timer); end
        tick = 1'b1;
        near();
        cyc();
        tick = 1'b0;
        far();
        checks++; if (mode !== 2'b10 || timer !== 12'd180 || ghost_eaten !== 1'b1) begin
            errors++; $display("FAIL b2b_eat: got mode %0d timer %0d eaten %0b expected 2 180 1", mode, timer, ghost_eaten);
        end
        pellet_eaten = 1'b1;
        cyc();
        pellet_eaten = 1'b0;
        repeat (10) do_tick();
        do_reset();
        checks++; if (mode !== 2'b00 || timer !== 12'd0 || frighten_warn !== 1'b0) begin
            errors++; $display("FAIL reset_abort: got mode %0d timer %0d warn %0b expected 0 0 0", mode, timer, frighten_warn);
        end
    endtask

`ifdef GHOST_SCATTER_EN
    task automatic test_scatter();
        do_reset();
        checks++; if (mode !== 2'b11 || timer !== 12'd0) begin
            errors++; $display("FAIL sc_reset: got mode %0d timer %0d expected 3 0", mode, timer);
        end
        repeat (419) do_tick();
        checks++; if (mode !== 2'b11) begin errors++; $display("FAIL sc_419: got %0d expected 3", mode); end
        do_tick();
        checks++; if (mode !== 2'b00) begin errors++; $display("FAIL sc_420: got %0d expected 0", mode); end
        repeat (700) do_tick();
        checks++; if (mode !== 2'b00) begin errors++; $display("FAIL sc_chase700: got %0d expected 0", mode); end
        pellet_eaten = 1'b1;
        cyc();
        pellet_eaten = 1'b0;
        checks++; if (mode !== 2'b01) begin errors++; $display("FAIL sc_fr: got %0d expected 1", mode); end
        repeat (360) do_tick();
        checks++; if (mode !== 2'b00 || timer !== 12'd0) begin
            errors++; $display("FAIL sc_return: got mode %0d timer %0d expected 0 0", mode, timer);
        end
        repeat (499) do_tick();
        checks++; if (mode !== 2'b00) begin errors++; $display("FAIL sc_499: got %0d expected 0", mode); end
        do_tick();
        checks++; if (mode !== 2'b11) begin errors++; $display("FAIL sc_500: got %0d expected 3", mode); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        tick = 1'b0;
        pellet_eaten = 1'b0;
        far();
`ifdef GHOST_SCATTER_EN
        test_scatter();
`else
        test_reset();
        test_idle();
        test_frighten();
        test_eaten();
        test_caught();
        test_back_to_back();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
